// File: rtl/param_memory.sv
// Parametrised single-port synchronous data memory with byte-lane strobes,
// a valid/ready request port, a pipelined read path and a post-reset clear.
module param_memory #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err,
  output logic                      busy
);

  localparam int unsigned LANES = DATA_WIDTH / 8;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [PTR_W-1:0] clear_ptr;
  logic [PTR_W-1:0] clear_ptr_next;
  logic             clear_we;
  logic             ready_next;
  logic             busy_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic             accept;
  logic             wr_accept;
  logic             rd_accept;
  logic             in_range;
  logic [PTR_W-1:0] mem_idx;

  logic [READ_LATENCY-1:0] pipe_vld;
  logic [READ_LATENCY-1:0] pipe_err;
  logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];

  assign accept    = req_valid & req_ready;
  assign wr_accept = accept & req_write;
  assign rd_accept = accept & ~req_write;
  // Full-width compare: out-of-range addresses never alias onto real words
  assign in_range  = 32'(req_addr) < DEPTH;
  assign mem_idx   = PTR_W'(req_addr);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clear_ptr <= '0;
      req_ready <= 1'b0;
      busy      <= (CLEAR_ON_RESET != 0);
    end else begin
      state     <= state_next;
      clear_ptr <= clear_ptr_next;
      req_ready <= ready_next;
      busy      <= busy_next;
    end
  end

  // Next-state: CLEAR walks every word once, leaving on the write of the last word
  always_comb begin
    state_next     = state;
    clear_ptr_next = clear_ptr;
    clear_we       = 1'b0;
    case (state)
      CLEAR: begin
        clear_we       = 1'b1;
        clear_ptr_next = clear_ptr + PTR_W'(1);
        if (clear_ptr == LAST_PTR) begin
          state_next     = RUN;
          clear_ptr_next = '0;
        end
      end
      RUN:     state_next = RUN;
      default: state_next = RUN;
    endcase
    ready_next = (state_next == RUN);
    busy_next  = (state_next == CLEAR);
  end

  // Storage: clear writes and lane-masked request writes; reset leaves contents alone
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clear_we) begin
        mem[clear_ptr] <= '0;
      end else if (wr_accept && in_range) begin
        for (int i = 0; i < LANES; i++) begin
          if (req_wstrb[i]) begin
            mem[mem_idx][8*i +: 8] <= req_wdata[8*i +: 8];
          end
        end
      end
    end
  end

  // Read pipeline; data/err stages only load behind a valid so the outputs hold
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_vld <= '0;
      pipe_err <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe_data[k] <= '0;
      end
    end else begin
      pipe_vld[0] <= rd_accept;
      if (rd_accept) begin
        pipe_err[0]  <= ~in_range;
        pipe_data[0] <= in_range ? mem[mem_idx] : '0;
      end
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        if (pipe_vld[k-1]) begin
          pipe_err[k]  <= pipe_err[k-1];
          pipe_data[k] <= pipe_data[k-1];
        end
      end
    end
  end

  assign rsp_valid = pipe_vld[READ_LATENCY-1];
  assign rsp_err   = pipe_err[READ_LATENCY-1];
  assign rsp_rdata = pipe_data[READ_LATENCY-1];

endmodule
